// File: rtl/videocard_clkgen_pkg.sv
// Shared definitions for the video card clock generator.
//   lock_state_e : states of the lock-tracking FSM
//   DEF_*        : default parameter values for the top and channel modules
//   cnt_width()  : number of bits needed to hold values 0..max_val
package videocard_clkgen_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,  // out of reset, waiting for every channel to settle
    ST_PEND   = 2'd1,  // a reconfiguration is parked in the slot
    ST_COUNT  = 2'd2,  // new ratio applied, counting pulses on the target
    ST_LOCKED = 2'd3
  } lock_state_e;

  localparam int          DEF_NUM_CH   = 2;
  localparam int          DEF_DIV_W    = 16;
  localparam logic [31:0] DEF_DIV_INIT = {16'd10, 16'd1};
  localparam int          DEF_LOCK_CNT = 4;

  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((64'd1 << w) <= 64'(max_val)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/videocard_clkgen_chan.sv
// One divided-clock channel.
//   refclk     : reference clock, rising edge
//   rst        : asynchronous active-low reset
//   load_en    : a new ratio is pending for this channel; taken at the next wrap
//   load_div   : pending ratio (0 is treated as 1)
//   wrap       : counter is at D-1, so the next edge starts a new period
//   outclk     : registered divided clock
//   outen      : registered one-cycle pulse at each period start
//   pulse_full : LOCK_CNT pulses seen at the current ratio (saturating)
module videocard_clkgen_chan
  import videocard_clkgen_pkg::*;
#(
  parameter int               DIV_W    = DEF_DIV_W,
  parameter int               LOCK_CNT = DEF_LOCK_CNT,
  parameter logic [DIV_W-1:0] DIV_INIT = DIV_W'(1)
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [DIV_W-1:0] load_div,
  output logic             wrap,
  output logic             outclk,
  output logic             outen,
  output logic             pulse_full
);

  localparam int                PCNT_W   = cnt_width(LOCK_CNT);
  localparam int                HALF_W   = DIV_W + 1;
  localparam logic [DIV_W-1:0]  D_RST    = (DIV_INIT == '0) ? DIV_W'(1) : DIV_INIT;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(LOCK_CNT);

  logic [DIV_W-1:0]  d_q, d_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              outclk_q, outclk_d;
  logic              outen_q, outen_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [HALF_W-1:0] half;

  // Reset parks the counter at D-1 so the first edge after release wraps
  // to 0 in every channel at once, aligning all period starts.
  assign wrap = (cnt_q == d_q - DIV_W'(1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    d_d    = d_q;
    cnt_d  = cnt_q + DIV_W'(1);
    pcnt_d = pcnt_q;

    // A new ratio is only taken at the wrap, so the running period always
    // completes and outclk never sees a truncated high or low phase.
    if (wrap) begin
      cnt_d = '0;
      if (load_en) d_d = (load_div == '0) ? DIV_W'(1) : load_div;
    end

    // Compare the next count against ceil(D/2) of the next ratio; for D=1
    // this is 0 < 1, which holds outclk constantly high.
    half     = ({1'b0, d_d} + HALF_W'(1)) >> 1;
    outclk_d = ({1'b0, cnt_d} < half);
    outen_d  = (cnt_d == '0);

    // The period started by the apply edge is the first pulse at the new ratio.
    if (wrap && load_en)                   pcnt_d = PCNT_W'(1);
    else if (outen_d && pcnt_q != PCNT_MAX) pcnt_d = pcnt_q + PCNT_W'(1);
  end

  always_ff @(posedge refclk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    if (!rst) begin
      d_q      <= D_RST;
      cnt_q    <= D_RST - DIV_W'(1);
      outclk_q <= 1'b0;
      outen_q  <= 1'b0;
      pcnt_q   <= '0;
    end else begin
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      outen_q  <= outen_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign outclk     = outclk_q;
  assign outen      = outen_q;
  assign pulse_full = (pcnt_q == PCNT_MAX);

endmodule

// File: rtl/videocard_clkgen.sv
// Multi-channel integer clock divider with a single reconfiguration slot
// and a lock indicator.
//   refclk    : sole clock, rising edge
//   rst       : asynchronous active-low reset
//   cfg_valid : reconfiguration request
//   cfg_ready : slot empty; request accepted when cfg_valid && cfg_ready
//   cfg_ch    : target channel (out-of-range requests are accepted and dropped)
//   cfg_div   : new divide ratio (0 is treated as 1)
//   outclk    : per-channel divided clock
//   outen     : per-channel one-cycle pulse at each period start
//   locked    : every channel running stably at its programmed ratio
module videocard_clkgen
  import videocard_clkgen_pkg::*;
#(
  parameter int                      NUM_CH   = DEF_NUM_CH,
  parameter int                      DIV_W    = DEF_DIV_W,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = DEF_DIV_INIT,
  parameter int                      LOCK_CNT = DEF_LOCK_CNT,
  localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outen,
  output logic              locked
);

  logic              slot_valid_q, slot_valid_d;
  logic [CH_W-1:0]   slot_ch_q, slot_ch_d;
  logic [DIV_W-1:0]  slot_div_q, slot_div_d;
  logic              cfg_ready_q, cfg_ready_d;
  lock_state_e       state_q;
  logic              locked_q;
  logic [CH_W-1:0]   tgt_q;

  logic [NUM_CH-1:0] load_en;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] pulse_full;
  logic              accept, accept_cfg, apply, tgt_full;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    videocard_clkgen_chan #(
      .DIV_W   (DIV_W),
      .LOCK_CNT(LOCK_CNT),
      .DIV_INIT(DIV_INIT[i*DIV_W +: DIV_W])
    ) u_chan (
      .refclk    (refclk),
      .rst       (rst),
      .load_en   (load_en[i]),
      .load_div  (slot_div_q),
      .wrap      (wrap[i]),
      .outclk    (outclk[i]),
      .outen     (outen[i]),
      .pulse_full(pulse_full[i])
    );
  end

  always_comb begin
    accept     = cfg_valid && cfg_ready_q;
    accept_cfg = accept && (int'(cfg_ch) < NUM_CH);

    load_en  = '0;
    tgt_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      load_en[i] = slot_valid_q && (int'(slot_ch_q) == i);
      if (int'(tgt_q) == i) tgt_full = pulse_full[i];
    end
    apply = |(load_en & wrap);

    // Apply empties the slot before a same-edge accept refills it.
    slot_valid_d = slot_valid_q;
    slot_ch_d    = slot_ch_q;
    slot_div_d   = slot_div_q;
    if (apply) slot_valid_d = 1'b0;
    if (accept_cfg) begin
      slot_valid_d = 1'b1;
      slot_ch_d    = cfg_ch;
      slot_div_d   = cfg_div;
    end
    cfg_ready_d = !slot_valid_d;
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      slot_valid_q <= 1'b0;
      slot_ch_q    <= '0;
      slot_div_q   <= '0;
      cfg_ready_q  <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_ch_q    <= slot_ch_d;
      slot_div_q   <= slot_div_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

  // Lock FSM. A fresh accept overrides every state, including a pending
  // apply on the same edge, so the target always tracks the newest request.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_WAIT;
      locked_q <= 1'b0;
      tgt_q    <= '0;
    end else if (accept_cfg) begin
      state_q  <= ST_PEND;
      locked_q <= 1'b0;
      tgt_q    <= cfg_ch;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (&pulse_full) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
          end
        end
        ST_PEND: begin
          if (apply) state_q <= ST_COUNT;
        end
        ST_COUNT: begin
          if (tgt_full) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          locked_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_WAIT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_videocard_clkgen.sv
// Directed bench for videocard_clkgen: a default 2-channel instance carries
// the reconfiguration sequences, a 3-channel instance covers out-of-range
// requests. Expected outputs come from the edge number n (1 = first edge
// after reset release) and the per-channel ratio/origin at that edge.
module tb_videocard_clkgen;

  logic        refclk;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [1:0]  outclk, outen;
  logic        locked;

  logic        b_valid, b_ready;
  logic [1:0]  b_ch;
  logic [15:0] b_div;
  logic [2:0]  b_outclk, b_outen;
  logic        b_locked;

  videocard_clkgen u_dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .outclk   (outclk),
    .outen    (outen),
    .locked   (locked)
  );

  videocard_clkgen #(
    .NUM_CH  (3),
    .DIV_INIT({16'd2, 16'd10, 16'd1})
  ) u_dut3 (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(b_valid),
    .cfg_ready(b_ready),
    .cfg_ch   (b_ch),
    .cfg_div  (b_div),
    .outclk   (b_outclk),
    .outen    (b_outen),
    .locked   (b_locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int edge_n;
    int ch;
    int d;
  } apply_t;

  apply_t sched[$];
  int n;
  int d2[2], o2[2];
  int d3[3], o3[3];
  int lk_off, lk_on, rd_off, rd_on, lk3_on;

  function automatic logic exp_clk(input int d, input int o, input int e);
    int c;
    c = (e - o) % d;
    if (d == 1) return 1'b1;
    return (c < (d + 1) / 2);
  endfunction

  function automatic logic exp_en(input int d, input int o, input int e);
    return ((e - o) % d) == 0;
  endfunction

  task automatic step();
    logic [1:0] ec2, ee2;
    logic [2:0] ec3, ee3;
    @(posedge refclk);
    #1;
    n++;
    foreach (sched[i]) begin
      if (sched[i].edge_n == n) begin
        d2[sched[i].ch] = sched[i].d;
        o2[sched[i].ch] = n;
      end
    end
    for (int i = 0; i < 2; i++) begin
      ec2[i] = exp_clk(d2[i], o2[i], n);
      ee2[i] = exp_en(d2[i], o2[i], n);
    end
    for (int i = 0; i < 3; i++) begin
      ec3[i] = exp_clk(d3[i], o3[i], n);
      ee3[i] = exp_en(d3[i], o3[i], n);
    end
    check($sformatf("e%0d a.outclk", n), 32'(outclk), 32'(ec2));
    check($sformatf("e%0d a.outen", n), 32'(outen), 32'(ee2));
    check($sformatf("e%0d a.locked", n), 32'(locked), 32'(!(n >= lk_off && n < lk_on)));
    check($sformatf("e%0d a.cfg_ready", n), 32'(cfg_ready), 32'(!(n >= rd_off && n < rd_on)));
    check($sformatf("e%0d b.outclk", n), 32'(b_outclk), 32'(ec3));
    check($sformatf("e%0d b.outen", n), 32'(b_outen), 32'(ee3));
    check($sformatf("e%0d b.locked", n), 32'(b_locked), 32'(n >= lk3_on));
    check($sformatf("e%0d b.cfg_ready", n), 32'(b_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " a.outclk"}, 32'(outclk), 32'd0);
    check({tag, " a.outen"}, 32'(outen), 32'd0);
    check({tag, " a.locked"}, 32'(locked), 32'd0);
    check({tag, " a.cfg_ready"}, 32'(cfg_ready), 32'd0);
    check({tag, " b.outclk"}, 32'(b_outclk), 32'd0);
    check({tag, " b.outen"}, 32'(b_outen), 32'd0);
    check({tag, " b.locked"}, 32'(b_locked), 32'd0);
    check({tag, " b.cfg_ready"}, 32'(b_ready), 32'd0);
  endtask

  // Model origin: every channel's counter reads 0 at edge n0+1.
  task automatic restart_model(input int n0);
    d2 = '{1, 10};
    o2 = '{n0 + 1, n0 + 1};
    d3 = '{1, 10, 2};
    o3 = '{n0 + 1, n0 + 1, n0 + 1};
    sched.delete();
    lk_off = 0;
    lk_on  = n0 + 32;
    lk3_on = n0 + 32;
    rd_off = 0;
    rd_on  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    b_valid   = 1'b0;
    b_ch      = '0;
    b_div     = '0;
    n         = 0;

    #12;
    check_reset_outputs("por");
    @(negedge refclk);
    rst = 1'b1;
    restart_model(0);

    // Defaults: ch0 D=1, ch1 D=10, lock at edge 32.
    repeat (44) step();

    // ch1 -> 5: accepted at 45, applied at ch1's wrap on 51, locked at 67.
    cfg_valid = 1'b1;
    cfg_ch    = 1'b1;
    cfg_div   = 16'd5;
    sched.push_back('{51, 1, 5});
    lk_off = 45; lk_on = 67;
    rd_off = 45; rd_on = 51;
    step();
    cfg_valid = 1'b0;
    repeat (30) step();

    // ch1 -> 0 (acts as 1): accepted at 76, applied at 81, locked at 85.
    cfg_valid = 1'b1;
    cfg_div   = 16'd0;
    sched.push_back('{81, 1, 1});
    lk_off = 76; lk_on = 85;
    rd_off = 76; rd_on = 81;
    step();
    cfg_valid = 1'b0;
    repeat (14) step();

    // Back-to-back: 4 accepted at 91 and applied at 92; 3 held on the bus,
    // accepted at 93, applied at ch1's wrap on 96; locked at 106.
    cfg_valid = 1'b1;
    cfg_div   = 16'd4;
    sched.push_back('{92, 1, 4});
    sched.push_back('{96, 1, 3});
    lk_off = 91; lk_on = 106;
    rd_off = 91; rd_on = 92;
    step();
    cfg_div = 16'd3;
    step();
    rd_off = 93; rd_on = 96;
    step();
    cfg_valid = 1'b0;
    repeat (17) step();

    // ch1 -> 7 on the 2-channel part (applied at 114); channel 3 request on
    // the 3-channel part is swallowed with no visible effect.
    cfg_valid = 1'b1;
    cfg_div   = 16'd7;
    b_valid   = 1'b1;
    b_ch      = 2'd3;
    b_div     = 16'd5;
    sched.push_back('{114, 1, 7});
    lk_off = 111; lk_on = 32'h4000_0000;
    rd_off = 111; rd_on = 114;
    step();
    cfg_valid = 1'b0;
    b_valid   = 1'b0;
    repeat (6) step();

    // Mid-period reset: outputs drop at once; ch1 comes back at D=10.
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst async");
    @(posedge refclk);
    #1;
    check_reset_outputs("rst held");
    @(negedge refclk);
    rst = 1'b1;
    restart_model(n);
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
